alu_share_arbiter: RTL and testbench

Round-robin controller that shares the single 2-bit ALU between two requesters: the local panel (finger decoder operand, op switches, confirm button) and the UART command path. It accepts one request at a time, drives the ALU operands, captures result and flags, and returns a response. It also updates the PWM duty register on every completed operation and sends a response byte on the UART transmitter for UART-originated requests. It sits between the input synchronisers / UART receiver and the ALU, PWM generator and UART transmitter in the top level.

---
 rtl/alu_share_arbiter.sv | 109 ++++++++++
 tb/tb_alu_share_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin owner of the shared ALU: accepts one request from the local
// panel or the UART path, runs it through the ALU and returns result/flags.
//
// state   | meaning
// IDLE    | waiting for a request, ready offered to the granted requester
// EXEC    | operands stable on the ALU, result captured at the edge
// RESP    | resp_valid pulse; UART responses start TX here if it is free
// TX_WAIT | UART response pending until the transmitter frees up
module alu_share_arbiter #(
  parameter int         W        = 2,
  parameter logic [1:0] RESP_PAD = 2'b00
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req0_valid,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic [1:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_o,
  input  logic         alu_c,
  output logic         resp_valid,
  output logic         resp_id,
  output logic [W-1:0] resp_result,
  output logic [3:0]   resp_flags,
  output logic [W-1:0] duty_cycle,
  output logic         tx_start,
  output logic [7:0]   tx_byte,
  input  logic         tx_busy,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP, TX_WAIT} state_t;

  state_t state;
  logic   last_grant;
  logic   in_idle;

  // Ready is masked during reset so nothing looks accepted while held in reset.
  assign in_idle    = (state == IDLE) && reset_n;
  assign req0_ready = in_idle && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = in_idle && req1_valid && (!req0_valid || !last_grant);

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign tx_start   = !tx_busy && (((state == RESP) && resp_id) || (state == TX_WAIT));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_flags  <= '0;
      duty_cycle  <= '0;
      tx_byte     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_op     <= req0_op;
            alu_a      <= req0_a;
            alu_b      <= req0_b;
            resp_id    <= 1'b0;
            last_grant <= 1'b0;
            state      <= EXEC;
          end else if (req1_ready) begin
            alu_op     <= req1_op;
            alu_a      <= req1_a;
            alu_b      <= req1_b;
            resp_id    <= 1'b1;
            last_grant <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_flags  <= {alu_c, alu_o, alu_n, alu_z};
          duty_cycle  <= alu_result;
          tx_byte     <= {alu_c, alu_o, alu_n, alu_z, RESP_PAD, alu_result};
          state       <= RESP;
        end
        RESP: begin
          if (resp_id && tx_busy) state <= TX_WAIT;
          else                    state <= IDLE;
        end
        TX_WAIT: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: reset, single requests, round-robin
// ties, UART response with and without a busy transmitter, reset mid-op.
module tb_alu_share_arbiter;

  localparam int W = 2;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         req0_valid, req1_valid;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_z, alu_n, alu_o, alu_c;
  logic         resp_valid, resp_id;
  logic [W-1:0] resp_result, duty_cycle;
  logic [3:0]   resp_flags;
  logic         tx_start, tx_busy, busy;
  logic [7:0]   tx_byte;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  alu_share_arbiter #(.W(W), .RESP_PAD(2'b00)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_z(alu_z), .alu_n(alu_n), .alu_o(alu_o), .alu_c(alu_c),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
    .resp_flags(resp_flags), .duty_cycle(duty_cycle),
    .tx_start(tx_start), .tx_byte(tx_byte), .tx_busy(tx_busy), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    req0_op = 2'd0; req0_a = '0; req0_b = '0;
    req1_op = 2'd0; req1_a = '0; req1_b = '0;
    alu_result = '0; {alu_c, alu_o, alu_n, alu_z} = 4'b0000;
    tx_busy = 1'b0;

    // Reset with both requesters pushing.
    req0_valid = 1'b1; req1_valid = 1'b1;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rdy0", req0_ready, 0);
      check("rst_rdy1", req1_ready, 0);
    end
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_resp_flags", resp_flags, 0);
    check("rst_duty", duty_cycle, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    // Single local request: op0, 2 and 1, ALU returns 3.
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 2'd2; req0_b = 2'd1;
    alu_result = 2'd3;
    #1;
    check("t1_rdy0", req0_ready, 1);
    check("t1_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_alu_op", alu_op, 0);
    check("t1_alu_a", alu_a, 2);
    check("t1_alu_b", alu_b, 1);
    check("t1_exec_vld", resp_valid, 0);
    tick();
    check("t1_resp_valid", resp_valid, 1);
    check("t1_resp_id", resp_id, 0);
    check("t1_resp_result", resp_result, 3);
    check("t1_duty", duty_cycle, 3);
    check("t1_tx_start", tx_start, 0);
    tick();
    check("t1_idle_vld", resp_valid, 0);
    check("t1_idle_busy", busy, 0);

    // Tie after reset: local, UART, local, UART.
    do_reset(1);
    req0_valid = 1'b1; req0_op = 2'd1; req0_a = 2'd1; req0_b = 2'd0;
    req1_valid = 1'b1; req1_op = 2'd2; req1_a = 2'd2; req1_b = 2'd3;
    alu_result = 2'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("tie_rdy0", req0_ready, (k % 2 == 0) ? 1 : 0);
      check("tie_rdy1", req1_ready, (k % 2 == 1) ? 1 : 0);
      tick();
      check("tie_exec_rdy", {req0_ready, req1_ready}, 0);
      check("tie_alu_a", alu_a, (k % 2 == 0) ? 1 : 2);
      tick();
      check("tie_resp_rdy", {req0_ready, req1_ready}, 0);
      check("tie_resp_valid", resp_valid, 1);
      check("tie_resp_id", resp_id, k % 2);
      check("tie_tx_start", tx_start, k % 2);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // UART request, transmitter free.
    req1_valid = 1'b1; req1_op = 2'd3; req1_a = 2'd3; req1_b = 2'd2;
    alu_result = 2'd1; {alu_c, alu_o, alu_n, alu_z} = 4'b1000;
    #1;
    check("t3_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    check("t3_resp_valid", resp_valid, 1);
    check("t3_resp_id", resp_id, 1);
    check("t3_flags", resp_flags, 4'b1000);
    check("t3_tx_start", tx_start, 1);
    check("t3_tx_byte", tx_byte, 8'b1000_0001);
    tick();
    check("t3_tx_start_off", tx_start, 0);

    // Same UART request with transmitter busy for 5 cycles after RESP.
    req1_valid = 1'b1;
    tx_busy = 1'b1;
    tick();
    req1_valid = 1'b0;
    tick();
    check("t4_resp_valid", resp_valid, 1);
    check("t4_resp_tx", tx_start, 0);
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 2'd1; req0_b = 2'd1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_wait_rdy0", req0_ready, 0);
      check("t4_wait_tx", tx_start, 0);
      check("t4_wait_busy", busy, 1);
      check("t4_wait_vld", resp_valid, 0);
      tick();
    end
    tx_busy = 1'b0;
    #1;
    check("t4_tx_start", tx_start, 1);
    check("t4_tx_byte", tx_byte, 8'h81);
    check("t4_rdy0_tx", req0_ready, 0);
    tick();
    check("t4_tx_off", tx_start, 0);
    check("t4_rdy0", req0_ready, 1);
    alu_result = 2'd2; {alu_c, alu_o, alu_n, alu_z} = 4'b0000;
    tick();
    req0_valid = 1'b0;
    check("t4_alu_a", alu_a, 1);
    tick();
    check("t4_resp_id", resp_id, 0);
    check("t4_duty", duty_cycle, 2);
    tick();

    // Reset during EXEC aborts the operation.
    req0_valid = 1'b1; req0_a = 2'd3; alu_result = 2'd3;
    tick();
    req0_valid = 1'b0;
    check("t5_in_exec", busy, 1);
    do_reset(1);
    check("t5_vld", resp_valid, 0);
    check("t5_duty", duty_cycle, 0);
    check("t5_busy", busy, 0);
    tick();
    check("t5_vld2", resp_valid, 0);
    check("t5_tx2", tx_start, 0);

    // Normal request after reset.
    req1_valid = 1'b1; req1_a = 2'd1; req1_b = 2'd2;
    alu_result = 2'd2; {alu_c, alu_o, alu_n, alu_z} = 4'b0110;
    #1;
    check("t5_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    check("t5_resp_valid", resp_valid, 1);
    check("t5_resp_result", resp_result, 2);
    check("t5_flags", resp_flags, 4'b0110);
    check("t5_tx_byte", tx_byte, 8'b0110_0010);
    check("t5_tx_start", tx_start, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
